gcd_param_unit: RTL and testbench

GCD_PARAM_UNIT -- requirements
Module: gcd_param_unit

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_param_unit_if.sv | 27 ++
 rtl/gcd_fsm.sv | 67 ++++++
 rtl/gcd_param_unit.sv | 94 +++++++++
 tb/tb_gcd_param_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD unit: FSM state encoding and default operand width.
package gcd_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/gcd_param_unit_if.sv
// Request/response bundle of the GCD unit; master issues operands, slave returns the result.
interface gcd_param_unit_if
   import gcd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) ();

   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             busy;
   logic             err;
   logic [WIDTH-1:0] iters;

   modport master (
      output start, a_in, b_in,
      input  result, done, busy, err, iters
   );

   modport slave (
      input  start, a_in, b_in,
      output result, done, busy, err, iters
   );

endinterface

// File: rtl/gcd_fsm.sv
// Sequencer for the subtractive GCD: sees only comparator flags, issues datapath strobes.
module gcd_fsm
   import gcd_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic a_zero,
   input  logic b_zero,
   input  logic a_eq_b,
   input  logic a_gt_b,
   output logic load,
   output logic sub_a,
   output logic sub_b,
   output logic latch,
   output logic done,
   output logic busy
);

   state_e state_q;
   state_e state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      sub_a   = 1'b0;
      sub_b   = 1'b0;
      latch   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            // A zero operand terminates as well, otherwise A-B would never converge.
            if (a_zero || b_zero || a_eq_b) begin
               latch   = 1'b1;
               state_d = ST_DONE;
            end else if (a_gt_b) begin
               sub_a = 1'b1;
            end else begin
               sub_b = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign done = (state_q == ST_DONE);
   assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/gcd_param_unit.sv
// Subtractive GCD unit: operand registers, comparator, subtractor and step counter around gcd_fsm.
module gcd_param_unit
   import gcd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic            clk,
   input  logic            reset,
   gcd_param_unit_if.slave bus
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] iters_q, iters_d;
   logic             err_q, err_d;

   logic a_zero, b_zero, a_eq_b, a_gt_b;
   logic load, sub_a, sub_b, latch;

   assign a_zero = (a_q == '0);
   assign b_zero = (b_q == '0);
   assign a_eq_b = (a_q == b_q);
   assign a_gt_b = (a_q > b_q);

   gcd_fsm u_fsm (
      .clk    (clk),
      .reset  (reset),
      .start  (bus.start),
      .a_zero (a_zero),
      .b_zero (b_zero),
      .a_eq_b (a_eq_b),
      .a_gt_b (a_gt_b),
      .load   (load),
      .sub_a  (sub_a),
      .sub_b  (sub_b),
      .latch  (latch),
      .done   (bus.done),
      .busy   (bus.busy)
   );

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      iters_d  = iters_q;
      err_d    = err_q;
      if (load) begin
         a_d   = bus.a_in;
         b_d   = bus.b_in;
         cnt_d = '0;
         err_d = 1'b0;
      end
      // The larger operand is always the minuend, so the difference never wraps.
      if (sub_a) begin
         a_d   = a_q - b_q;
         cnt_d = cnt_q + WIDTH'(1);
      end
      if (sub_b) begin
         b_d   = b_q - a_q;
         cnt_d = cnt_q + WIDTH'(1);
      end
      if (latch) begin
         result_d = a_zero ? b_q : a_q;
         iters_d  = cnt_q;
         err_d    = a_zero && b_zero;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         iters_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         iters_q  <= iters_d;
         err_q    <= err_d;
      end
   end

   assign bus.result = result_q;
   assign bus.iters  = iters_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_gcd_param_unit.sv
// Scoreboard bench for gcd_param_unit: 8-bit and 16-bit instances, directed vectors.
module tb_gcd_param_unit;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gcd_param_unit_if #(.WIDTH(8))  bus8 ();
   gcd_param_unit_if #(.WIDTH(16)) bus16 ();

   gcd_param_unit #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   gcd_param_unit #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16.slave)
   );

   typedef struct {
      int unsigned res;
      int unsigned it;
      bit          err;
      int          cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   int   tests = 0;
   int   fails = 0;
   int   done8_cnt = 0;
   int   done16_cnt = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (reset && bus8.done === 1'b1) begin
         done8_cnt++;
         if (q8.size() == 0) begin
            chk("unexpected_done8", 1, 0);
         end else begin
            exp_t e;
            e = q8.pop_front();
            chk("result8", 64'(bus8.result), 64'(e.res));
            chk("iters8", 64'(bus8.iters), 64'(e.it));
            chk("err8", 64'(bus8.err), 64'(e.err));
            chk("latency8", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (reset && bus16.done === 1'b1) begin
         done16_cnt++;
         if (q16.size() == 0) begin
            chk("unexpected_done16", 1, 0);
         end else begin
            exp_t e;
            e = q16.pop_front();
            chk("result16", 64'(bus16.result), 64'(e.res));
            chk("iters16", 64'(bus16.iters), 64'(e.it));
            chk("err16", 64'(bus16.err), 64'(e.err));
            chk("latency16", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // n is the hand-counted number of subtractions; done appears n+2 cycles after the drive edge.
   task automatic issue(input bit wide, input int a, input int b, input int res,
                        input int n, input bit e, input bit expect_done);
      int guard = 0;
      @(negedge clk);
      while ((wide ? bus16.busy : bus8.busy) !== 1'b0 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (wide) begin
         bus16.a_in  = a[15:0];
         bus16.b_in  = b[15:0];
         bus16.start = 1'b1;
         if (expect_done) q16.push_back('{res, n, e, cyc + n + 2});
      end else begin
         bus8.a_in  = a[7:0];
         bus8.b_in  = b[7:0];
         bus8.start = 1'b1;
         if (expect_done) q8.push_back('{res, n, e, cyc + n + 2});
      end
      @(negedge clk);
      bus8.start  = 1'b0;
      bus16.start = 1'b0;
   endtask

   task automatic drain(input int bound);
      int k = 0;
      while ((q8.size() != 0 || q16.size() != 0) && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (q8.size() != 0 || q16.size() != 0) begin
         chk("drain_timeout", 64'(q8.size() + q16.size()), 0);
         q8.delete();
         q16.delete();
      end
   endtask

   task automatic chk_outputs_zero(string tag);
      chk({tag, "_result"}, 64'(bus8.result), 0);
      chk({tag, "_iters"}, 64'(bus8.iters), 0);
      chk({tag, "_done"}, 64'(bus8.done), 0);
      chk({tag, "_busy"}, 64'(bus8.busy), 0);
      chk({tag, "_err"}, 64'(bus8.err), 0);
   endtask

   initial begin
      int c;
      int base;
      bus8.start  = 1'b0;
      bus8.a_in   = '0;
      bus8.b_in   = '0;
      bus16.start = 1'b0;
      bus16.a_in  = '0;
      bus16.b_in  = '0;

      repeat (3) @(negedge clk);
      chk_outputs_zero("rst8");
      chk("rst16_result", 64'(bus16.result), 0);
      chk("rst16_busy", 64'(bus16.busy), 0);
      reset = 1'b1;

      issue(0, 12, 8, 4, 2, 0, 1);
      drain(50);

      issue(0, 0, 9, 9, 0, 0, 1);
      drain(50);
      issue(0, 0, 0, 0, 0, 1, 1);
      drain(50);
      @(negedge clk);
      chk("err_held", 64'(bus8.err), 1);
      issue(0, 200, 200, 200, 0, 0, 1);
      chk("err_cleared_on_start", 64'(bus8.err), 0);
      drain(50);

      // Operand inputs wiggle mid-computation and must be ignored.
      issue(0, 255, 1, 1, 254, 0, 1);
      bus8.a_in = 8'd3;
      bus8.b_in = 8'd6;
      drain(400);

      base = done8_cnt;
      issue(0, 12, 8, 4, 2, 0, 1);
      bus8.a_in  = 8'd7;
      bus8.b_in  = 8'd5;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      drain(50);
      repeat (10) @(negedge clk);
      chk("single_done_busy_start", 64'(done8_cnt - base), 1);

      // Start held through DONE->IDLE relaunches on the first IDLE edge.
      @(negedge clk);
      c = cyc;
      bus8.a_in  = 8'd0;
      bus8.b_in  = 8'd9;
      bus8.start = 1'b1;
      q8.push_back('{9, 0, 0, c + 2});
      @(negedge clk);
      @(negedge clk);
      bus8.a_in = 8'd21;
      bus8.b_in = 8'd14;
      q8.push_back('{7, 2, 0, c + 7});
      @(negedge clk);
      @(negedge clk);
      bus8.start = 1'b0;
      drain(50);

      base = done8_cnt;
      issue(0, 255, 1, 1, 254, 0, 0);
      repeat (20) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_outputs_zero("async_rst8");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (300) @(negedge clk);
      chk("no_done_after_abort", 64'(done8_cnt - base), 0);
      issue(0, 21, 14, 7, 2, 0, 1);
      drain(50);

      issue(1, 48, 18, 6, 4, 0, 1);
      drain(50);
      issue(1, 65535, 65534, 1, 65534, 0, 1);
      drain(70000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
